result_uart_dump: RTL and testbench

RESULT_UART_DUMP -- requirements
Module: result_uart_dump

---
 rtl/result_uart_dump.sv | 122 ++++++++++++
 tb/tb_result_uart_dump.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/result_uart_dump.sv
// Dumps a 320-bit snapshot of Processor results as a 42-byte 8N1 UART frame:
// sync 0xA5, forty result bytes (word MSB-byte first), then an XOR checksum.
module result_uart_dump #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [319:0] results,
    input  logic         start,
    output logic         tx,
    output logic         busy,
    output logic         done
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [5:0] LAST_BYTE = 6'd41;

    typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;

    state_t           state;
    logic [319:0]     snap;
    logic [7:0]       csum;
    logic [7:0]       cur_byte;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [5:0]       byte_idx;

    logic [5:0] next_idx;
    logic [7:0] next_byte;
    logic       period_end;

    // Frame byte idx (1..40) -> snapshot slice; byte 1 is output1[31:24].
    function automatic logic [7:0] snap_byte(input logic [319:0] s, input logic [5:0] idx);
        logic [5:0] k;
        logic [8:0] off;
        k   = idx - 6'd1;
        off = {k[5:2], 5'b0} + {4'b0, ~k[1:0], 3'b0};
        return s[off +: 8];
    endfunction

    assign next_idx   = byte_idx + 6'd1;
    assign next_byte  = (next_idx == LAST_BYTE) ? csum : snap_byte(snap, next_idx);
    assign period_end = (clk_cnt == LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            snap     <= '0;
            csum     <= '0;
            cur_byte <= '0;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !busy) begin
                        snap     <= results;
                        csum     <= '0;
                        cur_byte <= 8'hA5;
                        clk_cnt  <= '0;
                        bit_idx  <= '0;
                        byte_idx <= '0;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START_BIT;
                    end
                end
                START_BIT: begin
                    if (period_end) begin
                        clk_cnt <= '0;
                        tx      <= cur_byte[0];
                        state   <= DATA_BITS;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                DATA_BITS: begin
                    if (period_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            tx      <= 1'b1;
                            state   <= STOP_BIT;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                STOP_BIT: begin
                    if (period_end) begin
                        clk_cnt <= '0;
                        if (byte_idx == LAST_BYTE) begin
                            byte_idx <= '0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            // Checksum folds in each result byte as it is loaded for sending.
                            byte_idx <= next_idx;
                            cur_byte <= next_byte;
                            if (next_idx != LAST_BYTE)
                                csum <= csum ^ next_byte;
                            tx       <= 1'b0;
                            state    <= START_BIT;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_result_uart_dump.sv
// Bench for result_uart_dump: decodes the serial line and compares each frame
// against a frame built directly from the result words.
module tb_result_uart_dump;
    localparam int CPB   = 4;
    localparam int FRAME = 42 * 10 * CPB;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [319:0] results = '0;
    logic         tx, busy, done;

    result_uart_dump #(.CLKS_PER_BIT(CPB)) dut (
        .clock(clock), .reset(reset), .results(results), .start(start),
        .tx(tx), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [319:0] r;
        logic [31:0]  b14;
        logic [7:0]   cs;
    } vec_t;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] got [42];
    logic [7:0] exp_f [42];
    logic       line [FRAME];
    int         dones, shape_err, bad;
    vec_t       tv [4];
    logic [319:0] pre;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [319:0] r, output logic [7:0] f [42]);
        logic [31:0] w;
        logic [7:0]  x;
        x = 8'h00;
        f[0] = 8'hA5;
        for (int k = 0; k < 10; k++) begin
            w = r[32*k +: 32];
            for (int j = 0; j < 4; j++) begin
                f[1 + 4*k + j] = 8'(w >> (24 - 8*j));
                x ^= f[1 + 4*k + j];
            end
        end
        f[41] = x;
    endfunction

    function automatic logic [319:0] rand_results();
        logic [319:0] r;
        for (int k = 0; k < 10; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    // Request one frame; returns just after the accepting edge.
    task automatic kick();
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
    endtask

    // Samples one frame's worth of line cycles, then decodes bytes.
    task automatic capture(input bit corrupt);
        dones = 0;
        shape_err = 0;
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clock);
            line[c] = tx;
            if (done) dones++;
            if (!busy) shape_err++;
            if (corrupt && c == 0) results = '1;
        end
        for (int b = 0; b < 42; b++) begin
            for (int i = 0; i < 10; i++)
                for (int s = 1; s < CPB; s++)
                    if (line[(b*10 + i)*CPB + s] !== line[(b*10 + i)*CPB]) shape_err++;
            if (line[b*10*CPB] !== 1'b0) shape_err++;
            if (line[(b*10 + 9)*CPB] !== 1'b1) shape_err++;
            for (int i = 0; i < 8; i++) got[b][i] = line[(b*10 + 1 + i)*CPB];
        end
    endtask

    // Compares decoded frame with model, then checks the done cycle.
    task automatic check_frame(input logic [319:0] r, input string tag);
        model(r, exp_f);
        for (int b = 0; b < 42; b++)
            chk($sformatf("%s_byte%0d", tag, b), {24'h0, got[b]}, {24'h0, exp_f[b]});
        chk({tag, "_shape"}, shape_err, 0);
        chk({tag, "_early_done"}, dones, 0);
        @(negedge clock);
        chk({tag, "_done_at_1680"}, {30'h0, done, busy}, 32'h2);
    endtask

    initial begin
        tv[0] = '{320'h0, 32'h0, 8'h00};
        tv[1] = '{320'h12345678, 32'h12345678, 8'h08};
        tv[2] = '{{320{1'b1}}, 32'hFFFFFFFF, 8'h00};
        tv[3] = '{{32'h000000FF, 288'h0}, 32'h0, 8'hFF};

        // Held in reset with start asserted, then released with start low.
        reset = 1'b0; start = 1'b1;
        bad = 0;
        repeat (6) @(negedge clock) if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        chk("reset_hold", bad, 0);
        #2 start = 1'b0; reset = 1'b1;
        bad = 0;
        repeat (6) @(negedge clock) if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        chk("post_reset_idle", bad, 0);

        // Directed table
        for (int t = 0; t < 4; t++) begin
            results = tv[t].r;
            kick();
            capture(1'b0);
            chk($sformatf("tv%0d_b1_4", t), {got[1], got[2], got[3], got[4]}, tv[t].b14);
            chk($sformatf("tv%0d_csum", t), {24'h0, got[41]}, {24'h0, tv[t].cs});
            if (t == 0) begin
                logic [9:0] pat;
                for (int i = 0; i < 10; i++) pat[i] = line[i*CPB];
                chk("a5_line_pattern", {22'h0, pat}, {22'h0, 10'b1101001010});
            end
            check_frame(tv[t].r, $sformatf("tv%0d", t));
            @(negedge clock);
            chk($sformatf("tv%0d_done_width", t), {31'h0, done}, 32'h0);
        end

        // Results overwritten one cycle after acceptance
        pre = rand_results();
        results = pre;
        kick();
        capture(1'b1);
        check_frame(pre, "snapshot");

        // Randomised frames
        for (int n = 0; n < 3; n++) begin
            pre = rand_results();
            results = pre;
            kick();
            capture(1'b0);
            check_frame(pre, $sformatf("rand%0d", n));
        end

        // Start held high: back-to-back frames, one done each
        pre = rand_results();
        results = pre;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1;
        capture(1'b0);
        check_frame(pre, "b2b_a");
        pre = rand_results();
        results = pre;
        capture(1'b0);
        chk("b2b_restart_tx", {31'h0, line[0]}, 32'h0);
        check_frame(pre, "b2b_b");
        start = 1'b0;
        @(negedge clock);
        chk("b2b_stop_idle", {30'h0, busy, done}, 32'h0);

        // Reset asserted during byte 10
        results = rand_results();
        kick();
        repeat (10*10*CPB + 7) @(negedge clock);
        chk("pre_reset_busy", {31'h0, busy}, 32'h1);
        #2 reset = 1'b0; start = 1'b1;
        #1 chk("async_reset", {29'h0, tx, busy, done}, 32'h4);
        bad = 0;
        repeat (5) @(negedge clock) if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        chk("mid_reset_hold", bad, 0);
        #2 start = 1'b0; reset = 1'b1;
        pre = rand_results();
        results = pre;
        kick();
        capture(1'b0);
        check_frame(pre, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
